// File: rtl/op_sequencer_if.sv
// rtl/op_sequencer_if.sv - opr_mode_t package and board/datapath-facing interface of op_sequencer
package op_sequencer_pkg;
  typedef enum logic [2:0] {
    RESET        = 3'd0,
    MUL          = 3'd1,
    LEADING_ONES = 3'd2,
    COUNT_ONES   = 3'd3,
    ADD          = 3'd4,
    SUB          = 3'd5
  } opr_mode_t;
endpackage

interface op_sequencer_if #(
  parameter int WIDTH = 16
);
  import op_sequencer_pkg::*;

  logic             btnc_i;
  logic             btnu_i;
  logic             btnd_i;
  logic             btnl_i;
  logic             btnr_i;
  logic [WIDTH-1:0] sw_i;
  logic [WIDTH-1:0] result_i;
  opr_mode_t        sel_o;
  logic [WIDTH-1:0] sw_o;
  logic [WIDTH-1:0] led_o;
  logic             busy_o;
  logic             done_o;
  logic             overrun_o;

  modport master (
    input  btnc_i, btnu_i, btnd_i, btnl_i, btnr_i, sw_i, result_i,
    output sel_o, sw_o, led_o, busy_o, done_o, overrun_o
  );

  modport slave (
    output btnc_i, btnu_i, btnd_i, btnl_i, btnr_i, sw_i, result_i,
    input  sel_o, sw_o, led_o, busy_o, done_o, overrun_o
  );
endinterface

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - button conditioning and operand/result sequencing for select_action
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic            clk,
  input  logic            rst,
  op_sequencer_if.master  bus
);

  localparam int NB  = 5;
  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DCW-1:0] DB_MAX    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] SET_START = SCW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  // Bit order is the priority order: C, U, D, L, R
  logic [NB-1:0]  btn_raw;
  logic [NB-1:0]  sync1, sync2, deb, deb_prev, press;
  logic [DCW-1:0] db_cnt [NB];

  assign btn_raw = {bus.btnr_i, bus.btnl_i, bus.btnd_i, bus.btnu_i, bus.btnc_i};
  assign press   = deb & ~deb_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DCW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic      any_press;
  opr_mode_t press_mode;

  always_comb begin
    any_press  = |press;
    press_mode = RESET;
    if      (press[0]) press_mode = MUL;
    else if (press[1]) press_mode = LEADING_ONES;
    else if (press[2]) press_mode = COUNT_ONES;
    else if (press[3]) press_mode = ADD;
    else if (press[4]) press_mode = SUB;
  end

  state_t           state_q, state_d;
  opr_mode_t        sel_q, sel_d;
  logic [WIDTH-1:0] sw_q, sw_d, led_q, led_d;
  logic             busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic [SCW-1:0]   scnt_q, scnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= RESET;
      sw_q    <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sw_q    <= sw_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sw_d    = sw_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_press) begin
          state_d = SETTLE;
          sel_d   = press_mode;
          sw_d    = bus.sw_i;
          busy_d  = 1'b1;
          ovr_d   = 1'b0;
          scnt_d  = SET_START;
        end
      end
      SETTLE: begin
        if (any_press) ovr_d = 1'b1;
        if (scnt_q == '0) state_d = CAPTURE;
        else              scnt_d  = scnt_q - SCW'(1);
      end
      CAPTURE: begin
        if (any_press) ovr_d = 1'b1;
        led_d   = bus.result_i;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel_o     = sel_q;
  assign bus.sw_o      = sw_q;
  assign bus.led_o     = led_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.overrun_o = ovr_q;

endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - directed self-checking bench for op_sequencer
module tb_op_sequencer;
  import op_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   snap;

  op_sequencer_if #(.WIDTH(16)) bus ();

  op_sequencer #(
    .WIDTH(16), .DEBOUNCE_CYCLES(16), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: result = operand + (mode << 8)
  assign bus.result_i = bus.sw_o + {5'b0, bus.sel_o, 8'b0};

  always @(posedge clk) if (bus.done_o) done_cnt <= done_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.btnc_i = 0; bus.btnu_i = 0; bus.btnd_i = 0; bus.btnl_i = 0; bus.btnr_i = 0;
    bus.sw_i = 16'h0000;
    #1;
    check("rst_sel", 32'(bus.sel_o), 32'(RESET));
    check("rst_sw", 32'(bus.sw_o), 0);
    check("rst_led", 32'(bus.led_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    check("rst_ovr", 32'(bus.overrun_o), 0);
    tick(2);
    rst = 0;
    tick(2);

    // Clean BTNL press, event lands 18 edges after the raw edge
    bus.sw_i = 16'h0003;
    bus.btnl_i = 1;
    tick(19);
    check("add_sel_t1", 32'(bus.sel_o), 32'(ADD));
    check("add_sw_t1", 32'(bus.sw_o), 32'h0003);
    check("add_busy", 32'(bus.busy_o), 1);
    check("add_done_early", 32'(bus.done_o), 0);
    tick(2);
    check("add_done_early2", 32'(bus.done_o), 0);
    tick(1);
    check("add_done", 32'(bus.done_o), 1);
    check("add_led", 32'(bus.led_o), 32'h0403);
    check("add_busy_clr", 32'(bus.busy_o), 0);
    tick(1);
    check("add_done_pulse", 32'(bus.done_o), 0);
    bus.btnl_i = 0;
    tick(20);
    check("add_sel_sticky", 32'(bus.sel_o), 32'(ADD));

    // BTNC glitch one cycle short of the debounce window
    snap = done_cnt;
    bus.btnc_i = 1;
    tick(15);
    bus.btnc_i = 0;
    tick(25);
    check("glitch_sel", 32'(bus.sel_o), 32'(ADD));
    check("glitch_nodone", 32'(done_cnt - snap), 0);
    bus.btnc_i = 1;
    tick(22);
    check("mul_done", 32'(bus.done_o), 1);
    check("mul_sel", 32'(bus.sel_o), 32'(MUL));
    check("mul_led", 32'(bus.led_o), 32'h0103);
    bus.btnc_i = 0;
    tick(20);

    // BTNU and BTNR together: U wins, R silently dropped
    snap = done_cnt;
    bus.btnu_i = 1;
    bus.btnr_i = 1;
    tick(19);
    check("lo_sel", 32'(bus.sel_o), 32'(LEADING_ONES));
    tick(3);
    check("lo_done", 32'(bus.done_o), 1);
    check("lo_led", 32'(bus.led_o), 32'h0203);
    bus.btnu_i = 0;
    bus.btnr_i = 0;
    tick(20);
    check("lo_one_done", 32'(done_cnt - snap), 1);
    check("lo_sel_hold", 32'(bus.sel_o), 32'(LEADING_ONES));
    check("lo_no_ovr", 32'(bus.overrun_o), 0);

    // BTND, then BTNR arriving while busy
    bus.btnd_i = 1;
    tick(2);
    bus.btnr_i = 1;
    tick(17);
    check("cnt_sel", 32'(bus.sel_o), 32'(COUNT_ONES));
    tick(3);
    check("cnt_done", 32'(bus.done_o), 1);
    check("cnt_led", 32'(bus.led_o), 32'h0303);
    check("cnt_ovr", 32'(bus.overrun_o), 1);
    check("cnt_sel_hold", 32'(bus.sel_o), 32'(COUNT_ONES));
    bus.btnd_i = 0;
    bus.btnr_i = 0;
    tick(20);
    check("ovr_sticky", 32'(bus.overrun_o), 1);
    bus.btnr_i = 1;
    tick(19);
    check("sub_sel", 32'(bus.sel_o), 32'(SUB));
    check("sub_ovr_clr", 32'(bus.overrun_o), 0);
    tick(3);
    check("sub_done", 32'(bus.done_o), 1);
    check("sub_led", 32'(bus.led_o), 32'h0503);
    bus.btnr_i = 0;
    tick(20);

    // sw_i change during SETTLE is ignored
    bus.sw_i = 16'h00FF;
    bus.btnl_i = 1;
    tick(19);
    check("snap_sw", 32'(bus.sw_o), 32'h00FF);
    bus.sw_i = 16'hFFFF;
    tick(3);
    check("snap_done", 32'(bus.done_o), 1);
    check("snap_sw_hold", 32'(bus.sw_o), 32'h00FF);
    check("snap_led", 32'(bus.led_o), 32'h04FF);
    bus.btnl_i = 0;
    tick(20);

    // Reset mid-SETTLE with overrun pending
    bus.sw_i = 16'h0003;
    bus.btnc_i = 1;
    tick(1);
    bus.btnr_i = 1;
    tick(19);
    check("mid_busy", 32'(bus.busy_o), 1);
    check("mid_ovr", 32'(bus.overrun_o), 1);
    check("mid_sel", 32'(bus.sel_o), 32'(MUL));
    snap = done_cnt;
    rst = 1;
    #1;
    check("arst_sel", 32'(bus.sel_o), 32'(RESET));
    check("arst_sw", 32'(bus.sw_o), 0);
    check("arst_led", 32'(bus.led_o), 0);
    check("arst_busy", 32'(bus.busy_o), 0);
    check("arst_done", 32'(bus.done_o), 0);
    check("arst_ovr", 32'(bus.overrun_o), 0);
    bus.btnc_i = 0;
    bus.btnr_i = 0;
    tick(3);
    rst = 0;
    tick(30);
    check("arst_nodone", 32'(done_cnt - snap), 0);
    check("arst_led_hold", 32'(bus.led_o), 0);
    check("arst_sel_hold", 32'(bus.sel_o), 32'(RESET));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
